fir_output_sink: RTL and testbench

Output-side counterpart of `fir_filter`. It accepts the 32-bit FIR result stream, discards the pipeline warm-up samples, and requantizes each sample to 16 bits using round-half-up and optional saturation. Results are buffered in a small show-ahead FIFO, and downstream logic reads them over a valid/ready handshake. The block sits between `fir_filter` and any 16-bit consumer (DAC interface, capture RAM, UART framer).

---
 rtl/fir_output_sink.sv | 123 ++++++++++++
 tb/tb_fir_output_sink.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fir_output_sink.sv
// FIR output sink: drops the filter warm-up samples, requantizes 32-bit results to 16 bits
// (round-half-up), and buffers them in a show-ahead FIFO. Define FIR_SINK_SAT_EN for saturating narrowing.
module fir_output_sink #(
   parameter int N3    = 32,
   parameter int N2    = 16,
   parameter int SHIFT = 8,
   parameter int SKIP  = 7,
   parameter int DEPTH = 8
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     ENABLE,
   input  logic [N3-1:0]            fir_data,
   input  logic                     fir_valid,
   output logic [N2-1:0]            out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     ovf_clr
);

   localparam int AW  = $clog2(DEPTH);
   localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
   localparam logic [SKW-1:0] SKIP_INIT = SKW'(SKIP);
   localparam logic [N3:0]    RND       = (N3+1)'(1) << (SHIFT - 1);
   localparam logic [AW:0]    FULL_CNT  = (AW+1)'(DEPTH);

   logic                  accept;
   logic                  pass;
   logic [SKW-1:0]        skip_rem;
   logic [N3:0]           q_sum;
   logic signed [N3:0]    q_shr;
   logic [N2-1:0]         q_narrow;
   logic                  st_valid;
   logic [N2-1:0]         st_data;
   logic [N2-1:0]         mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  full;
   logic                  rd;
   logic                  wr_ok;
   logic                  drop;

   assign accept = ENABLE & fir_valid;
   assign pass   = (skip_rem == '0);

   // Warm-up skip runs as a down-counter; samples pass once it reaches terminal count zero.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         skip_rem <= SKIP_INIT;
      end else if (accept && !pass) begin
         skip_rem <= skip_rem - SKW'(1);
      end
   end

   assign q_sum = {fir_data[N3-1], fir_data} + RND;
   assign q_shr = $signed(q_sum) >>> SHIFT;

`ifdef FIR_SINK_SAT_EN
   logic [N3-N2+1:0] q_hi;
   logic             q_in_range;
   assign q_hi       = q_shr[N3:N2-1];
   assign q_in_range = (&q_hi) | ~(|q_hi);
   always_comb begin
      q_narrow = q_shr[N2-1:0];
      if (!q_in_range) begin
         q_narrow = q_shr[N3] ? {1'b1, {(N2-1){1'b0}}} : {1'b0, {(N2-1){1'b1}}};
      end
   end
`else
   logic unused_q_hi;
   assign unused_q_hi = ^q_shr[N3:N2];
   assign q_narrow    = q_shr[N2-1:0];
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         st_valid <= 1'b0;
         st_data  <= '0;
      end else begin
         st_valid <= accept & pass;
         if (accept && pass) begin
            st_data <= q_narrow;
         end
      end
   end

   assign full  = (count == FULL_CNT);
   assign rd    = out_valid & out_ready;
   // A full FIFO still takes the write when the head leaves on the same edge.
   assign wr_ok = st_valid & (~full | rd);
   assign drop  = st_valid & full & ~rd;

   always_ff @(posedge CLK) begin
      if (wr_ok) begin
         mem[wr_ptr] <= st_data;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (rd)    rd_ptr <= rd_ptr + AW'(1);
         case ({wr_ok, rd})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (drop)         overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   assign out_valid = (count != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fir_output_sink.sv
// Bench for fir_output_sink: directed test-plan steps plus random traffic, checked every cycle
// against a queue-based reference model. Honours FIR_SINK_SAT_EN like the design.
module tb_fir_output_sink;

   localparam int N3    = 32;
   localparam int N2    = 16;
   localparam int SHIFT = 8;
   localparam int SKIP  = 7;
   localparam int DEPTH = 8;

   logic           CLK = 1'b0;
   logic           RST;
   logic           ENABLE;
   logic [N3-1:0]  fir_data;
   logic           fir_valid;
   logic [N2-1:0]  out_data;
   logic           out_valid;
   logic           out_ready;
   logic [3:0]     count;
   logic           overflow;
   logic           ovf_clr;

   int checks = 0;
   int errors = 0;

   // reference model state
   int          m_skipped;
   bit          m_st_v;
   logic [15:0] m_st_d;
   logic [15:0] m_q[$];
   bit          m_ovf;

   fir_output_sink #(.N3(N3), .N2(N2), .SHIFT(SHIFT), .SKIP(SKIP), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .fir_data(fir_data), .fir_valid(fir_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .count(count), .overflow(overflow), .ovf_clr(ovf_clr)
   );

   always #5 CLK = ~CLK;

   function automatic logic [15:0] q16(logic [31:0] d);
      longint v, r;
      v = longint'($signed(d));
      r = (v + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
`ifdef FIR_SINK_SAT_EN
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
`endif
      return r[15:0];
   endfunction

   task automatic model_reset();
      m_skipped = 0;
      m_st_v    = 0;
      m_st_d    = '0;
      m_q.delete();
      m_ovf     = 0;
   endtask

   task automatic model_step();
      bit rd, drop, acc;
      rd   = (m_q.size() != 0) && out_ready;
      drop = 0;
      if (rd) void'(m_q.pop_front());
      if (m_st_v) begin
         if (m_q.size() < DEPTH) m_q.push_back(m_st_d);
         else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      acc    = ENABLE && fir_valid;
      m_st_v = acc && (m_skipped >= SKIP);
      if (m_st_v) m_st_d = q16(fir_data);
      if (acc && m_skipped < SKIP) m_skipped++;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      logic [15:0] exp_d;
      exp_d = (m_q.size() != 0) ? m_q[0] : 16'h0;
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_q.size() != 0));
      chk({tag, ".out_data"},  32'(out_data),  32'(exp_d));
      chk({tag, ".count"},     32'(count),     32'(m_q.size()));
      chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
   endtask

   task automatic cyc(string tag);
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      check_all(tag);
   endtask

   task automatic send(string tag, logic [31:0] d);
      ENABLE    = 1'b1;
      fir_valid = 1'b1;
      fir_data  = d;
      cyc(tag);
   endtask

   task automatic idle(string tag, int n);
      fir_valid = 1'b0;
      for (int i = 0; i < n; i++) cyc(tag);
   endtask

   initial begin
      RST = 1'b0; ENABLE = 1'b0; fir_valid = 1'b0; fir_data = '0;
      out_ready = 1'b0; ovf_clr = 1'b0;
      model_reset();
      #2 check_all("reset");
      @(negedge CLK);
      RST = 1'b1;

      // warm-up: 7 dropped, three 0x0001 outputs
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) send("warmup", 32'h0000_0100);
      idle("warmup_tail", 3);

      send("round_a", 32'h0000_0180);
      send("round_b", 32'h0000_017F);
      send("round_c", 32'hFFFF_FE80);
      send("round_d", 32'hFFFF_FE7F);
      idle("round_tail", 3);

      send("sat_pos", 32'h0100_0000);
      send("sat_neg", 32'h8000_0000);
      idle("sat_tail", 3);

      // fill past capacity with the consumer stalled
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) send("fill", 32'h0000_1000 + 32'(i) * 32'h100);
      idle("fill_tail", 2);
      chk("full_count", 32'(count), 32'd8);
      chk("full_ovf", 32'(overflow), 32'd1);
      out_ready = 1'b1;
      idle("drain", 9);
      chk("drain_count", 32'(count), 32'd0);
      ovf_clr = 1'b1;
      cyc("ovf_clr");
      ovf_clr = 1'b0;
      chk("ovf_cleared", 32'(overflow), 32'd0);

      // full FIFO with reads and writes on the same edge
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send("fill8", 32'h0000_2000 + 32'(i) * 32'h100);
      idle("fill8_tail", 1);
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) send("stream_full", 32'h0000_3000 + 32'(i) * 32'h100);
      chk("stream_full_ovf", 32'(overflow), 32'd0);
      idle("stream_tail", 10);

      // reset mid-stream with five entries queued
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send("pre_rst", 32'h0000_4000 + 32'(i) * 32'h100);
      idle("pre_rst_tail", 2);
      chk("pre_rst_count", 32'(count), 32'd5);
      #2 RST = 1'b0;
      model_reset();
      #1 check_all("async_rst");
      @(negedge CLK);
      RST = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) send("post_rst", 32'h0000_0100 + 32'(i) * 32'h100);
      idle("post_rst_tail", 3);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         ENABLE    = ($urandom_range(0, 3) != 0);
         fir_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 6);
         ovf_clr   = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 2))
            0:       fir_data = $urandom;
            1:       fir_data = 32'($signed(20'($urandom)));
            default: fir_data = 32'($signed(12'($urandom)));
         endcase
         cyc("random");
      end
      fir_valid = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
      idle("final_drain", 12);
      chk("final_count", 32'(count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
